instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes instruction symbols from the shared instruction-symbol set back into 32-bit MIPS32 machine words. Each symbol arrives with its register, shift, immediate and target fields, and each result is streamed as an instruction-memory write with an auto-incrementing word address. The block is the inverse of the symbol decode/classify path. Its job is to load IM images from symbolic programs in the self-test harness and boot loader, ahead of the CPU leaving reset. It is a 2-stage pipeline with valid/ready handshakes on both sides and a capacity limit of `DEPTH` words.

## Interface
- `BASE_ADDR`, 32'h0000_3000, byte address of the first emitted word.
- `DEPTH`, 1024, maximum number of words emitted between resets/clears.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `clear` in 1: synchronous; same effect as reset on the next edge.
- `in_valid` in 1: input word offered.
- `in_ready` out 1: block can accept.
- `instr` in `WIDTH_INSTR: instruction symbol.
- `rs`, `rt`, `rd`, `shamt` in 5 each: register and shift fields.
- `imm` in 16: immediate or branch offset.
- `target` in 26: jump index.
- `out_valid` out 1: `im_addr`/`im_wdata` valid (IM write request).
- `out_ready` in 1: IM accepts this cycle.
- `im_addr` out 32: byte address of the word.
- `im_wdata` out 32: encoded machine word.
- `count` out 11: words delivered (out handshakes) since reset/clear.
- `full` out 1: reserved words == `DEPTH`.
- `err` out 1: sticky; an unknown symbol was accepted.

## Operation
- Encodings follow MIPS32 Vol. II exactly.
- R-type: op 0, with funct.
  - `SLL`/`SRL`/`SRA`: rs forced 0.
  - `SLLV`/`SRLV`/`SRAV`: shamt forced 0.
  - Other ALU R-type: shamt 0.
  - `NOP` = 32'h0.
- MD group: op 0.
  - MULT/MULTU/DIV/DIVU: funct 0x18/0x19/0x1A/0x1B; rd and shamt are 0.
  - MFHI/MFLO: funct 0x10/0x12; rd only.
  - MTHI/MTLO: funct 0x11/0x13; rs only.
- Jumps:
  - `JR`: funct 0x08, rs only.
  - `JALR`: funct 0x09, rd and rs.
  - `J`/`JAL`: op 0x02/0x03 with `target`.
- I-type: `{op, rs, rt, imm}`.
  - `LUI`: rs forced 0.
  - `BLEZ`/`BGTZ`: rt forced 0.
  - REGIMM (op 1): rt = 0/1/16/17 for BLTZ/BGEZ/BLTZAL/BGEZAL.
- Fields not used by a format are forced to 0, whatever the input value.
- Input handshake: a word is accepted when `in_valid && in_ready`.
  - `in_ready = !full && (!s1_valid || s1_advance)`.
  - `s1_advance = !s2_valid || out_ready`.
- Known symbol accepted:
  - S1 loads the symbol and fields.
  - `reserved` increments.
- Unknown symbol accepted:
  - Consumed and dropped immediately.
  - Sets `err`.
  - Does not enter S1, consume an address or change `reserved`.
- Encoding:
  - S1 → S2 encodes combinationally and registers the word.
  - The address is assigned at output: `im_addr = BASE_ADDR + 4*count`.
- Output handshake: on `out_valid && out_ready`, `count` increments.
  - S2 holds `im_addr`/`im_wdata` stable while `out_valid && !out_ready`.
- Capacity: `full = (reserved == DEPTH)`.
  - Once full, `in_ready` = 0 until reset/clear.
  - In-flight words still drain.
- `clear` and `in_valid` in the same cycle: `clear` wins; the input is not accepted.

## Timing
- Reset values:
  - `in_ready` = 1; `out_valid` = 0; `im_addr` = `BASE_ADDR`; `im_wdata` = 0.
  - `count` = 0; `full` = 0; `err` = 0.
  - s1/s2 are empty; `reserved` = 0.
- Latency: a word accepted at edge N is driven with `out_valid` = 1 after edge N+1.
  - It is written at the first edge ≥ N+2 with `out_ready` = 1.
- Throughput: 1 word/cycle while `out_ready` stays high.
- Buffering: with `out_ready` low, 2 words are buffered (S2, S1); then `in_ready` drops in the same cycle that S1 fills.
- Ordering: strictly in order; there is no reordering and no drop of known symbols.
- `reset` asserted mid-stream: all in-flight words are discarded asynchronously; no partial write follows.
- `count`/`full` update on the same edge as the causing handshake.
- `err` rises on the edge that accepts the unknown symbol.

## Test plan
- ADDU rd=3 rs=1 rt=2 → `im_wdata` 0x00221821 at `im_addr` 0x3000, two cycles after acceptance; `count` = 1.
- Sequence LW rt=8 rs=29 imm=0xFFFC; J target=0x0000C01; BGEZAL rs=4 imm=3 → words 0x8FA8FFFC, 0x08000C01, 0x04910003 at 0x3000/0x3004/0x3008, back-to-back.
- `out_ready` held low for 4 cycles with `in_valid` held high → exactly 2 words accepted and `in_ready` = 0; after release, words emerge in order with `out_valid` and data stable while stalled.
- `DEPTH`=4, 5 known words offered → 4 accepted, `full` = 1, `in_ready` = 0; last write at 0x300C; `count` = 4.
- Unknown symbol between two ADDUs → `err` = 1 (sticky); only 2 writes, at 0x3000 and 0x3004.
- `reset` pulsed while S1 and S2 are full → `out_valid` drops immediately; the next accepted word is written at 0x3000 with `count` = 1 and `err` = 0. Repeat using `clear`: same result.

Source files
------------

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Turns instruction symbols (with their register/shift/immediate/target
// fields) back into 32-bit MIPS32 machine words and streams them out as
// instruction-memory writes at auto-incrementing word addresses.
//
// Two-stage pipeline:
//   S1 holds the accepted symbol and its raw fields.
//   S2 holds the encoded word.
// Both sides use valid/ready handshakes. At most DEPTH words are reserved
// between resets/clears.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-high reset
//   clear      in   synchronous clear, same effect as reset
//   in_valid   in   symbol offered
//   in_ready   out  block can accept a symbol
//   instr      in   instruction symbol (codes listed below)
//   rs, rt     in   register fields
//   rd, shamt  in   register fields
//   imm        in   immediate / branch offset
//   target     in   jump index
//   out_valid  out  im_addr/im_wdata form an IM write request
//   out_ready  in   IM accepts the request this cycle
//   im_addr    out  byte address of the word (BASE_ADDR + 4*count)
//   im_wdata   out  encoded machine word
//   count      out  words delivered since reset/clear
//   full       out  DEPTH words reserved
//   err        out  sticky: an unknown symbol was accepted
//
// Symbol codes: see the SYM_* localparams. Codes >= N_SYMS are unknown.
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH       = 1024,
    parameter int          WIDTH_INSTR = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_INSTR-1:0] instr,
    input  logic [4:0]             rs,
    input  logic [4:0]             rt,
    input  logic [4:0]             rd,
    input  logic [4:0]             shamt,
    input  logic [15:0]            imm,
    input  logic [25:0]            target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            im_addr,
    output logic [31:0]            im_wdata,
    output logic [10:0]            count,
    output logic                   full,
    output logic                   err
);

    // Instruction symbol set.
    localparam logic [5:0] SYM_NOP  = 6'd0,  SYM_SLL   = 6'd1,  SYM_SRL   = 6'd2,  SYM_SRA    = 6'd3;
    localparam logic [5:0] SYM_SLLV = 6'd4,  SYM_SRLV  = 6'd5,  SYM_SRAV  = 6'd6,  SYM_ADD    = 6'd7;
    localparam logic [5:0] SYM_ADDU = 6'd8,  SYM_SUB   = 6'd9,  SYM_SUBU  = 6'd10, SYM_AND    = 6'd11;
    localparam logic [5:0] SYM_OR   = 6'd12, SYM_XOR   = 6'd13, SYM_NOR   = 6'd14, SYM_SLT    = 6'd15;
    localparam logic [5:0] SYM_SLTU = 6'd16, SYM_MULT  = 6'd17, SYM_MULTU = 6'd18, SYM_DIV    = 6'd19;
    localparam logic [5:0] SYM_DIVU = 6'd20, SYM_MFHI  = 6'd21, SYM_MFLO  = 6'd22, SYM_MTHI   = 6'd23;
    localparam logic [5:0] SYM_MTLO = 6'd24, SYM_JR    = 6'd25, SYM_JALR  = 6'd26, SYM_J      = 6'd27;
    localparam logic [5:0] SYM_JAL  = 6'd28, SYM_BEQ   = 6'd29, SYM_BNE   = 6'd30, SYM_BLEZ   = 6'd31;
    localparam logic [5:0] SYM_BGTZ = 6'd32, SYM_BLTZ  = 6'd33, SYM_BGEZ  = 6'd34, SYM_BLTZAL = 6'd35;
    localparam logic [5:0] SYM_BGEZAL = 6'd36, SYM_ADDI = 6'd37, SYM_ADDIU = 6'd38, SYM_SLTI  = 6'd39;
    localparam logic [5:0] SYM_SLTIU = 6'd40, SYM_ANDI = 6'd41, SYM_ORI   = 6'd42, SYM_XORI   = 6'd43;
    localparam logic [5:0] SYM_LUI  = 6'd44, SYM_LB    = 6'd45, SYM_LH    = 6'd46, SYM_LW     = 6'd47;
    localparam logic [5:0] SYM_LBU  = 6'd48, SYM_LHU   = 6'd49, SYM_SB    = 6'd50, SYM_SH     = 6'd51;
    localparam logic [5:0] SYM_SW   = 6'd52;
    localparam int         N_SYMS   = 53;

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    // Format builders; unused fields are passed as zero by the caller.
    function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                           input logic [4:0] f_rd, input logic [4:0] f_sh,
                                           input logic [5:0] fn);
        return {6'h00, f_rs, f_rt, f_rd, f_sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [15:0] f_imm);
        return {op, f_rs, f_rt, f_imm};
    endfunction

    // Pipeline state
    logic        s1_valid_q, s1_valid_d;
    logic [5:0]  s1_sym_q, s1_sym_d;
    logic [4:0]  s1_rs_q, s1_rs_d, s1_rt_q, s1_rt_d, s1_rd_q, s1_rd_d, s1_sh_q, s1_sh_d;
    logic [15:0] s1_imm_q, s1_imm_d;
    logic [25:0] s1_tgt_q, s1_tgt_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_word_q, s2_word_d;
    logic [10:0] count_q, count_d;
    logic [10:0] reserved_q, reserved_d;
    logic        err_q, err_d;

    logic        s1_advance, accept, sym_known, out_fire;
    logic [31:0] enc_word;

    assign sym_known  = (32'(instr) < 32'(N_SYMS));
    assign full       = (reserved_q == DEPTH_W);
    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !full && (!s1_valid_q || s1_advance);
    // A simultaneous clear takes priority over the input handshake.
    assign accept     = in_valid && in_ready && !clear;
    assign out_fire   = s2_valid_q && out_ready;

    assign out_valid  = s2_valid_q;
    assign im_wdata   = s2_word_q;
    assign im_addr    = BASE_ADDR + {19'b0, count_q, 2'b00};
    assign count      = count_q;
    assign err        = err_q;

    // S1 -> S2 encoder
    always_comb begin
        enc_word = 32'h0;
        case (s1_sym_q)
            SYM_NOP:    enc_word = 32'h0;
            SYM_SLL:    enc_word = r_word(5'd0, s1_rt_q, s1_rd_q, s1_sh_q, 6'h00);
            SYM_SRL:    enc_word = r_word(5'd0, s1_rt_q, s1_rd_q, s1_sh_q, 6'h02);
            SYM_SRA:    enc_word = r_word(5'd0, s1_rt_q, s1_rd_q, s1_sh_q, 6'h03);
            SYM_SLLV:   enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h04);
            SYM_SRLV:   enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h06);
            SYM_SRAV:   enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h07);
            SYM_ADD:    enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h20);
            SYM_ADDU:   enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h21);
            SYM_SUB:    enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h22);
            SYM_SUBU:   enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h23);
            SYM_AND:    enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h24);
            SYM_OR:     enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h25);
            SYM_XOR:    enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h26);
            SYM_NOR:    enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h27);
            SYM_SLT:    enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h2A);
            SYM_SLTU:   enc_word = r_word(s1_rs_q, s1_rt_q, s1_rd_q, 5'd0, 6'h2B);
            SYM_MULT:   enc_word = r_word(s1_rs_q, s1_rt_q, 5'd0, 5'd0, 6'h18);
            SYM_MULTU:  enc_word = r_word(s1_rs_q, s1_rt_q, 5'd0, 5'd0, 6'h19);
            SYM_DIV:    enc_word = r_word(s1_rs_q, s1_rt_q, 5'd0, 5'd0, 6'h1A);
            SYM_DIVU:   enc_word = r_word(s1_rs_q, s1_rt_q, 5'd0, 5'd0, 6'h1B);
            SYM_MFHI:   enc_word = r_word(5'd0, 5'd0, s1_rd_q, 5'd0, 6'h10);
            SYM_MFLO:   enc_word = r_word(5'd0, 5'd0, s1_rd_q, 5'd0, 6'h12);
            SYM_MTHI:   enc_word = r_word(s1_rs_q, 5'd0, 5'd0, 5'd0, 6'h11);
            SYM_MTLO:   enc_word = r_word(s1_rs_q, 5'd0, 5'd0, 5'd0, 6'h13);
            SYM_JR:     enc_word = r_word(s1_rs_q, 5'd0, 5'd0, 5'd0, 6'h08);
            SYM_JALR:   enc_word = r_word(s1_rs_q, 5'd0, s1_rd_q, 5'd0, 6'h09);
            SYM_J:      enc_word = {6'h02, s1_tgt_q};
            SYM_JAL:    enc_word = {6'h03, s1_tgt_q};
            SYM_BEQ:    enc_word = i_word(6'h04, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_BNE:    enc_word = i_word(6'h05, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_BLEZ:   enc_word = i_word(6'h06, s1_rs_q, 5'd0, s1_imm_q);
            SYM_BGTZ:   enc_word = i_word(6'h07, s1_rs_q, 5'd0, s1_imm_q);
            // REGIMM: the rt field selects the branch flavour
            SYM_BLTZ:   enc_word = i_word(6'h01, s1_rs_q, 5'd0, s1_imm_q);
            SYM_BGEZ:   enc_word = i_word(6'h01, s1_rs_q, 5'd1, s1_imm_q);
            SYM_BLTZAL: enc_word = i_word(6'h01, s1_rs_q, 5'd16, s1_imm_q);
            SYM_BGEZAL: enc_word = i_word(6'h01, s1_rs_q, 5'd17, s1_imm_q);
            SYM_ADDI:   enc_word = i_word(6'h08, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_ADDIU:  enc_word = i_word(6'h09, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_SLTI:   enc_word = i_word(6'h0A, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_SLTIU:  enc_word = i_word(6'h0B, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_ANDI:   enc_word = i_word(6'h0C, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_ORI:    enc_word = i_word(6'h0D, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_XORI:   enc_word = i_word(6'h0E, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_LUI:    enc_word = i_word(6'h0F, 5'd0, s1_rt_q, s1_imm_q);
            SYM_LB:     enc_word = i_word(6'h20, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_LH:     enc_word = i_word(6'h21, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_LW:     enc_word = i_word(6'h23, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_LBU:    enc_word = i_word(6'h24, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_LHU:    enc_word = i_word(6'h25, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_SB:     enc_word = i_word(6'h28, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_SH:     enc_word = i_word(6'h29, s1_rs_q, s1_rt_q, s1_imm_q);
            SYM_SW:     enc_word = i_word(6'h2B, s1_rs_q, s1_rt_q, s1_imm_q);
            default:    enc_word = 32'h0;
        endcase
    end

    // Next-state logic
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sym_d   = s1_sym_q;
        s1_rs_d    = s1_rs_q;
        s1_rt_d    = s1_rt_q;
        s1_rd_d    = s1_rd_q;
        s1_sh_d    = s1_sh_q;
        s1_imm_d   = s1_imm_q;
        s1_tgt_d   = s1_tgt_q;
        s2_valid_d = s2_valid_q;
        s2_word_d  = s2_word_q;
        count_d    = count_q;
        reserved_d = reserved_q;
        err_d      = err_q;

        // Unknown symbols are swallowed here and never reach S1.
        if (accept && sym_known) begin
            s1_valid_d = 1'b1;
            s1_sym_d   = 6'(instr);
            s1_rs_d    = rs;
            s1_rt_d    = rt;
            s1_rd_d    = rd;
            s1_sh_d    = shamt;
            s1_imm_d   = imm;
            s1_tgt_d   = target;
            reserved_d = reserved_q + 11'd1;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        // S2 only moves when its current word has been taken (or is empty),
        // so the write request stays stable under back-pressure.
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_word_d = enc_word;
            end
        end

        if (out_fire) begin
            count_d = count_q + 11'd1;
        end

        if (accept && !sym_known) begin
            err_d = 1'b1;
        end

        if (clear) begin
            s1_valid_d = 1'b0;
            s1_sym_d   = 6'd0;
            s1_rs_d    = 5'd0;
            s1_rt_d    = 5'd0;
            s1_rd_d    = 5'd0;
            s1_sh_d    = 5'd0;
            s1_imm_d   = 16'd0;
            s1_tgt_d   = 26'd0;
            s2_valid_d = 1'b0;
            s2_word_d  = 32'd0;
            count_d    = 11'd0;
            reserved_d = 11'd0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sym_q   <= 6'd0;
            s1_rs_q    <= 5'd0;
            s1_rt_q    <= 5'd0;
            s1_rd_q    <= 5'd0;
            s1_sh_q    <= 5'd0;
            s1_imm_q   <= 16'd0;
            s1_tgt_q   <= 26'd0;
            s2_valid_q <= 1'b0;
            s2_word_q  <= 32'd0;
            count_q    <= 11'd0;
            reserved_q <= 11'd0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sym_q   <= s1_sym_d;
            s1_rs_q    <= s1_rs_d;
            s1_rt_q    <= s1_rt_d;
            s1_rd_q    <= s1_rd_d;
            s1_sh_q    <= s1_sh_d;
            s1_imm_q   <= s1_imm_d;
            s1_tgt_q   <= s1_tgt_d;
            s2_valid_q <= s2_valid_d;
            s2_word_q  <= s2_word_d;
            count_q    <= count_d;
            reserved_q <= reserved_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed-vector bench for instr_encoder (DEPTH = 4 so capacity limits are
// reachable). Expected words are hand-encoded MIPS32 constants. A negedge
// monitor logs every IM write (address, data, cycle) for later comparison.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam logic [5:0] S_NOP = 6'd0,  S_SLL = 6'd1,  S_ADDU = 6'd8, S_MULT = 6'd17;
    localparam logic [5:0] S_MFHI = 6'd21, S_JALR = 6'd26, S_J = 6'd27, S_BLEZ = 6'd31;
    localparam logic [5:0] S_BGEZAL = 6'd36, S_LUI = 6'd44, S_LW = 6'd47, S_BAD = 6'd60;

    typedef struct packed {
        logic [5:0]  sym;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    logic        clk, reset, clear, in_valid, in_ready, out_valid, out_ready, full, err;
    logic [5:0]  instr;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] im_addr, im_wdata;
    logic [10:0] count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    instr_encoder #(
        .BASE_ADDR  (32'h0000_3000),
        .DEPTH      (4),
        .WIDTH_INSTR(6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .imm      (imm),
        .target   (target),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .count    (count),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake seen at negedge means the write happens at the next posedge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            wa_q.push_back(im_addr);
            wd_q.push_back(im_wdata);
            wc_q.push_back(cyc);
            $display("write addr=%h data=%h cycle=%0d", im_addr, im_wdata, cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic vec_t mk(input logic [5:0] s, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [4:0] d, input logic [15:0] i,
                                input logic [25:0] t, input logic [31:0] e);
        return '{sym: s, rs: a, rt: b, rd: c, sh: d, imm: i, tgt: t, exp: e};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input vec_t v);
        instr  = v.sym;
        rs     = v.rs;
        rt     = v.rt;
        rd     = v.rd;
        shamt  = v.sh;
        imm    = v.imm;
        target = v.tgt;
    endtask

    // Offer one symbol until accepted (bounded); returns at accept edge + 2.
    task automatic send(input vec_t v);
        bit done = 0;
        drive(v);
        in_valid = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            step();
        end
        in_valid = 0;
        check("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic hard_reset();
        step();
        reset = 1;
        #2;
        reset = 0;
        step();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] addr,
                               input logic [31:0] data);
        if (idx < wa_q.size()) begin
            check({tag, "_addr"}, wa_q[idx], addr);
            check({tag, "_data"}, wd_q[idx], data);
        end else begin
            check({tag, "_present"}, 32'(wa_q.size()), 32'(idx + 1));
        end
    endtask

    vec_t v_addu1, v_lw, v_j, v_bgezal, v_sll, v_lui, v_mult, v_mfhi, v_jalr, v_blez;
    vec_t v_addu2, v_bad, v_nop;
    vec_t stall_t[3];
    vec_t dep_t[4];

    initial begin
        v_addu1  = mk(S_ADDU,   5'd1,  5'd2, 5'd3,  5'd7, 16'hFFFF, 26'h3FFFFFF, 32'h0022_1821);
        v_lw     = mk(S_LW,     5'd29, 5'd8, 5'd3,  5'd2, 16'hFFFC, 26'h0,       32'h8FA8_FFFC);
        v_j      = mk(S_J,      5'd7,  5'd9, 5'd11, 5'd13, 16'h1234, 26'h0000C01, 32'h0800_0C01);
        v_bgezal = mk(S_BGEZAL, 5'd4,  5'd5, 5'd6,  5'd1, 16'h0003, 26'h0,       32'h0491_0003);
        v_sll    = mk(S_SLL,    5'd9,  5'd5, 5'd4,  5'd3, 16'h0,    26'h0,       32'h0005_20C0);
        v_lui    = mk(S_LUI,    5'd3,  5'd7, 5'd2,  5'd1, 16'h1234, 26'h0,       32'h3C07_1234);
        v_mult   = mk(S_MULT,   5'd2,  5'd3, 5'd8,  5'd4, 16'h0,    26'h0,       32'h0043_0018);
        v_mfhi   = mk(S_MFHI,   5'd1,  5'd2, 5'd5,  5'd6, 16'h0,    26'h0,       32'h0000_2810);
        v_jalr   = mk(S_JALR,   5'd6,  5'd4, 5'd31, 5'd2, 16'h0,    26'h0,       32'h00C0_F809);
        v_blez   = mk(S_BLEZ,   5'd9,  5'd3, 5'd0,  5'd0, 16'h0010, 26'h0,       32'h1920_0010);
        v_addu2  = mk(S_ADDU,   5'd5,  5'd6, 5'd4,  5'd0, 16'h0,    26'h0,       32'h00A6_2021);
        v_bad    = mk(S_BAD,    5'd1,  5'd1, 5'd1,  5'd1, 16'h1,    26'h1,       32'h0);
        v_nop    = mk(S_NOP,    5'd3,  5'd3, 5'd3,  5'd3, 16'h3,    26'h3,       32'h0);
        stall_t  = '{v_sll, v_lui, v_addu1};
        dep_t    = '{v_mult, v_mfhi, v_jalr, v_blez};

        clk = 0; reset = 1; clear = 0; in_valid = 0; out_ready = 0;
        instr = 0; rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0; target = 0;

        // Reset values
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_im_addr",   im_addr,        32'h3000);
        check("rst_im_wdata",  im_wdata,       32'h0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_full",      32'(full),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        reset = 0;
        step();

        // Single ADDU: latency and first address
        out_ready = 1;
        send(v_addu1);
        @(negedge clk);
        check("t1_s1_only_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_wdata",     im_wdata,       32'h0022_1821);
        check("t1_addr",      im_addr,        32'h3000);
        @(negedge clk);
        check("t1_count",       32'(count),     32'd1);
        check("t1_valid_after", 32'(out_valid), 32'd0);
        check("t1_next_addr",   im_addr,        32'h3004);
        check("t1_writes",      32'(wa_q.size()), 32'd1);

        // Back-to-back LW, J, BGEZAL
        hard_reset();
        out_ready = 1;
        send(v_lw);
        send(v_j);
        send(v_bgezal);
        repeat (4) step();
        check("t2_writes", 32'(wa_q.size()), 32'd3);
        check_write("t2_w0", 0, 32'h3000, v_lw.exp);
        check_write("t2_w1", 1, 32'h3004, v_j.exp);
        check_write("t2_w2", 2, 32'h3008, v_bgezal.exp);
        if (wc_q.size() == 3) begin
            check("t2_b2b_01", 32'(wc_q[1] - wc_q[0]), 32'd1);
            check("t2_b2b_12", 32'(wc_q[2] - wc_q[1]), 32'd1);
        end
        check("t2_count", 32'(count), 32'd3);

        // Back-pressure: out_ready low for 4 cycles, input always offered
        hard_reset();
        out_ready = 0;
        begin
            int  idx = 0;
            bit  acc;
            drive(stall_t[0]);
            in_valid = 1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                acc = in_ready;
                if (c >= 2) begin
                    check("t3_stall_valid", 32'(out_valid), 32'd1);
                    check("t3_stall_data",  im_wdata,       stall_t[0].exp);
                    check("t3_stall_addr",  im_addr,        32'h3000);
                end
                step();
                if (acc && idx < 2) begin
                    idx++;
                    drive(stall_t[idx]);
                end else if (acc) begin
                    idx++;
                end
            end
            check("t3_accepted", 32'(idx), 32'd2);
            check("t3_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 0;
        out_ready = 1;
        repeat (5) step();
        check("t3_writes", 32'(wa_q.size()), 32'd2);
        check_write("t3_w0", 0, 32'h3000, stall_t[0].exp);
        check_write("t3_w1", 1, 32'h3004, stall_t[1].exp);

        // Capacity: DEPTH = 4, a fifth word must be refused
        hard_reset();
        out_ready = 1;
        for (int i = 0; i < 4; i++) send(dep_t[i]);
        check("t4_full_now",     32'(full),     32'd1);
        check("t4_in_ready_now", 32'(in_ready), 32'd0);
        drive(v_addu2);
        in_valid = 1;
        repeat (5) step();
        check("t4_in_ready_held", 32'(in_ready), 32'd0);
        check("t4_full_held",     32'(full),     32'd1);
        in_valid = 0;
        check("t4_writes", 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_write($sformatf("t4_w%0d", i), i, 32'h3000 + 32'(4 * i), dep_t[i].exp);
        check("t4_count", 32'(count), 32'd4);

        // Unknown symbol between two ADDUs
        hard_reset();
        out_ready = 1;
        check("t5_err_before", 32'(err), 32'd0);
        send(v_addu1);
        send(v_bad);
        check("t5_err_set", 32'(err), 32'd1);
        send(v_addu2);
        repeat (4) step();
        check("t5_err_sticky", 32'(err), 32'd1);
        check("t5_writes", 32'(wa_q.size()), 32'd2);
        check_write("t5_w0", 0, 32'h3000, v_addu1.exp);
        check_write("t5_w1", 1, 32'h3004, v_addu2.exp);
        check("t5_count", 32'(count), 32'd2);

        // Asynchronous reset with S1 and S2 occupied
        hard_reset();
        out_ready = 0;
        send(v_bad);
        send(v_lw);
        send(v_j);
        check("t6_pre_valid",    32'(out_valid), 32'd1);
        check("t6_pre_in_ready", 32'(in_ready),  32'd0);
        check("t6_pre_err",      32'(err),       32'd1);
        reset = 1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_err",   32'(err),       32'd0);
        check("t6_rst_ready", 32'(in_ready),  32'd1);
        #1;
        reset = 0;
        step();
        out_ready = 1;
        send(v_nop);
        repeat (3) step();
        check("t6_writes", 32'(wa_q.size()), 32'd1);
        check_write("t6_w0", 0, 32'h3000, v_nop.exp);
        check("t6_count", 32'(count), 32'd1);
        check("t6_err",   32'(err),   32'd0);

        // Synchronous clear with S1 and S2 occupied; clear also beats in_valid
        hard_reset();
        out_ready = 0;
        send(v_bad);
        send(v_lw);
        send(v_j);
        check("t7_pre_valid", 32'(out_valid), 32'd1);
        clear = 1;
        step();
        check("t7_clr_valid", 32'(out_valid), 32'd0);
        check("t7_clr_err",   32'(err),       32'd0);
        check("t7_clr_count", 32'(count),     32'd0);
        check("t7_clr_ready", 32'(in_ready),  32'd1);
        drive(v_sll);
        in_valid  = 1;
        out_ready = 1;
        step();
        clear    = 0;
        in_valid = 0;
        repeat (3) step();
        check("t7_no_write", 32'(wa_q.size()), 32'd0);
        send(v_addu2);
        repeat (3) step();
        check("t7_writes", 32'(wa_q.size()), 32'd1);
        check_write("t7_w0", 0, 32'h3000, v_addu2.exp);
        check("t7_count", 32'(count), 32'd1);
        check("t7_err",   32'(err),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
